// File: rtl/sprite_line_scheduler.sv
// Prefetches up to four sprite rows for the next scanline into a back bank,
// then swaps banks at end of line and paints the front bank as 1-bit pixels.
module sprite_line_scheduler (
    input  logic         clk,
    input  logic         reset,
    input  logic [125:0] entities,
    input  logic [9:0]   counter_H,
    input  logic [9:0]   counter_V,
    output logic         rom_req,
    output logic [3:0]   rom_sprite_id,
    output logic [1:0]   rom_orient,
    output logic [2:0]   rom_line,
    input  logic         rom_valid,
    input  logic [7:0]   rom_data,
    output logic         colour,
    output logic         busy,
    output logic         overflow,
    output logic         late
);

    // state   | meaning
    // S_IDLE  | waiting for H==640 on a line whose successor is visible
    // S_SCAN  | examining entity slot slot_q against the target tile row
    // S_FETCH | request presented to the sprite ROM
    // S_WAIT  | request outstanding, waiting for rom_valid
    // S_DONE  | all slots scanned; falls back to S_IDLE next cycle
    typedef enum logic [2:0] {S_IDLE, S_SCAN, S_FETCH, S_WAIT, S_DONE} state_t;

    state_t      state_q;
    logic [3:0]  slot_q;
    logic [3:0]  row_q;
    logic [2:0]  sub_q;
    logic [3:0]  col_q;
    logic        rom_req_q;
    logic [3:0]  rom_id_q;
    logic [1:0]  rom_orient_q;
    logic [2:0]  rom_line_q;
    logic        overflow_q;
    logic        late_q;
    logic        colour_q;
    logic        colour_d;

    logic [2:0]  back_cnt_q;
    logic [3:0]  back_col_q  [4];
    logic [7:0]  back_dat_q  [4];
    logic [2:0]  front_cnt_q;
    logic [3:0]  front_col_q [4];
    logic [7:0]  front_dat_q [4];

    logic [9:0]  next_line;
    logic        start;
    logic [3:0]  start_row;
    logic [2:0]  start_sub;
    logic [13:0] cur_ent;
    logic        cur_hit;
    logic        end_of_line;
    logic [3:0]  pix_col;
    logic [2:0]  pix_bit;

    assign next_line   = counter_V + 10'd1;
    assign start       = (counter_H == 10'd640) && (next_line < 10'd480);
    assign start_row   = 4'(next_line / 10'd40);
    assign start_sub   = 3'((next_line % 10'd40) / 10'd5);
    assign end_of_line = (counter_H == 10'd799);

    always_comb begin
        cur_ent = 14'h3FFF;
        for (int k = 0; k < 9; k++) begin
            if (slot_q == 4'(k)) cur_ent = entities[14*k +: 14];
        end
    end

    assign cur_hit = (cur_ent[13:10] != 4'hF) && (cur_ent[7:4] == row_q);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            slot_q       <= 4'd0;
            row_q        <= 4'd0;
            sub_q        <= 3'd0;
            col_q        <= 4'd0;
            rom_req_q    <= 1'b0;
            rom_id_q     <= 4'd0;
            rom_orient_q <= 2'd0;
            rom_line_q   <= 3'd0;
            overflow_q   <= 1'b0;
            late_q       <= 1'b0;
            back_cnt_q   <= 3'd0;
            front_cnt_q  <= 3'd0;
            for (int k = 0; k < 4; k++) begin
                back_col_q[k]  <= 4'd0;
                back_dat_q[k]  <= 8'd0;
                front_col_q[k] <= 4'd0;
                front_dat_q[k] <= 8'd0;
            end
        end else if (end_of_line) begin
            // Swap wins over everything, including a rom_valid on this edge.
            for (int k = 0; k < 4; k++) begin
                front_col_q[k] <= back_col_q[k];
                front_dat_q[k] <= back_dat_q[k];
            end
            front_cnt_q <= back_cnt_q;
            back_cnt_q  <= 3'd0;
            rom_req_q   <= 1'b0;
            state_q     <= S_IDLE;
            if (state_q != S_DONE && state_q != S_IDLE) late_q <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q    <= S_SCAN;
                        slot_q     <= 4'd0;
                        back_cnt_q <= 3'd0;
                        overflow_q <= 1'b0;
                        late_q     <= 1'b0;
                        row_q      <= start_row;
                        sub_q      <= start_sub;
                    end
                end
                S_SCAN: begin
                    if (cur_hit && back_cnt_q != 3'd4) begin
                        state_q      <= S_FETCH;
                        rom_req_q    <= 1'b1;
                        rom_id_q     <= cur_ent[13:10];
                        rom_orient_q <= cur_ent[9:8];
                        rom_line_q   <= sub_q;
                        col_q        <= cur_ent[3:0];
                    end else begin
                        if (cur_hit) overflow_q <= 1'b1;
                        if (slot_q == 4'd8) state_q <= S_DONE;
                        else                slot_q  <= slot_q + 4'd1;
                    end
                end
                S_FETCH: state_q <= S_WAIT;
                S_WAIT: begin
                    if (rom_valid) begin
                        back_col_q[back_cnt_q[1:0]] <= col_q;
                        back_dat_q[back_cnt_q[1:0]] <= rom_data;
                        back_cnt_q <= back_cnt_q + 3'd1;
                        rom_req_q  <= 1'b0;
                        if (slot_q == 4'd8) begin
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_SCAN;
                            slot_q  <= slot_q + 4'd1;
                        end
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign pix_col = 4'(counter_H / 10'd40);
    assign pix_bit = 3'((counter_H % 10'd40) / 10'd5);

    // Walk entries from high to low so the lowest matching index wins.
    always_comb begin
        colour_d = 1'b1;
        if (counter_H < 10'd640 && counter_V < 10'd480) begin
            for (int k = 3; k >= 0; k--) begin
                if (3'(k) < front_cnt_q && front_col_q[k] == pix_col)
                    colour_d = front_dat_q[k][pix_bit];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) colour_q <= 1'b1;
        else        colour_q <= colour_d;
    end

    assign rom_req       = rom_req_q;
    assign rom_sprite_id = rom_id_q;
    assign rom_orient    = rom_orient_q;
    assign rom_line      = rom_line_q;
    assign colour        = colour_q;
    assign busy          = (state_q != S_IDLE);
    assign overflow      = overflow_q;
    assign late          = late_q;

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Randomised and directed scanline scenarios for sprite_line_scheduler,
// checked through an expectation queue drained by a separate monitor.
module tb_sprite_line_scheduler;

    localparam int K_COL = 0, K_REQ = 1, K_BUSY = 2, K_OVF = 3, K_LATE = 4;
    localparam int K_BCNT = 5, K_CLR = 6, K_QEMPTY = 7, K_FIELDS = 8;
    localparam logic [125:0] ALLF = {126{1'b1}};

    logic         clk = 1'b0;
    logic         reset;
    logic [125:0] entities;
    logic [9:0]   counter_H, counter_V;
    logic         rom_req;
    logic [3:0]   rom_sprite_id;
    logic [1:0]   rom_orient;
    logic [2:0]   rom_line;
    logic         rom_valid = 1'b0;
    logic [7:0]   rom_data = 8'd0;
    logic         colour, busy, overflow, late;

    always #5 clk = ~clk;

    sprite_line_scheduler dut (
        .clk(clk), .reset(reset), .entities(entities),
        .counter_H(counter_H), .counter_V(counter_V),
        .rom_req(rom_req), .rom_sprite_id(rom_sprite_id),
        .rom_orient(rom_orient), .rom_line(rom_line),
        .rom_valid(rom_valid), .rom_data(rom_data),
        .colour(colour), .busy(busy), .overflow(overflow), .late(late)
    );

    typedef struct { int cyc; int kind; int val; int h; int v; } cexp_t;
    typedef struct { logic [3:0] id; logic [1:0] orient; logic [2:0] line; } rexp_t;

    cexp_t      expq[$];
    rexp_t      reqq[$];
    logic [3:0] st_col[$];
    logic [7:0] st_dat[$];

    int errors = 0, checks = 0;
    int cyc = 0;
    int test_id = 0;
    int rom_mode = 0, rom_delay = 1;
    logic [7:0] rom_tab [4];
    int exp_busy;
    bit exp_ovf, exp_late;

    always @(posedge clk) cyc <= cyc + 1;

    // Sprite ROM: mode 0 answers each request after rom_delay cycles,
    // mode 1 never answers, mode 2 fires a stray pulse at H==720.
    always @(negedge clk) begin : rom_model
        static int seen_id = 0, ridx = 0, wcnt = 0;
        static bit pending = 0;
        if (test_id != seen_id) begin
            seen_id = test_id; ridx = 0; pending = 0;
        end
        if (rom_valid) begin
            rom_valid = 1'b0; pending = 0;
        end else if (rom_mode == 2) begin
            if (counter_H == 10'd720) begin rom_valid = 1'b1; rom_data = 8'hA5; end
        end else if (pending) begin
            if (wcnt == 0) begin
                rom_valid = 1'b1; rom_data = rom_tab[ridx]; ridx++;
            end else wcnt--;
        end else if (rom_req && rom_mode == 0) begin
            pending = 1; wcnt = rom_delay - 1;
        end
    end

    function automatic string kname(input int k);
        case (k)
            K_COL: return "colour"; K_REQ: return "rom_req"; K_BUSY: return "busy";
            K_OVF: return "overflow"; K_LATE: return "late"; K_BCNT: return "busy_cycles";
            K_QEMPTY: return "missing_requests"; default: return "rom_fields";
        endcase
    endfunction

    always @(negedge clk) begin : monitor
        static logic req_prev = 1'b0;
        static int busy_cnt = 0;
        cexp_t e;
        rexp_t r;
        int act;
        while (expq.size() > 0 && expq[0].cyc < cyc) begin
            e = expq.pop_front();
            if (e.kind == K_CLR) begin
                busy_cnt = 0;
            end else begin
                case (e.kind)
                    K_COL:    act = int'(colour);
                    K_REQ:    act = int'(rom_req);
                    K_BUSY:   act = int'(busy);
                    K_OVF:    act = int'(overflow);
                    K_LATE:   act = int'(late);
                    K_BCNT:   act = busy_cnt;
                    K_QEMPTY: act = reqq.size();
                    default:  act = int'({rom_sprite_id, rom_orient, rom_line});
                endcase
                checks++;
                if (act != e.val) begin
                    errors++;
                    $display("FAIL %s v=%0d h=%0d got %0d expected %0d",
                             kname(e.kind), e.v, e.h, act, e.val);
                end
            end
        end
        busy_cnt += int'(busy);
        if (rom_req && !req_prev) begin
            checks++;
            if (reqq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_request id=%0d line=%0d expected none",
                         rom_sprite_id, rom_line);
            end else begin
                r = reqq.pop_front();
                if ({rom_sprite_id, rom_orient, rom_line} !== {r.id, r.orient, r.line}) begin
                    errors++;
                    $display("FAIL request got id=%0d or=%0d line=%0d expected id=%0d or=%0d line=%0d",
                             rom_sprite_id, rom_orient, rom_line, r.id, r.orient, r.line);
                end
            end
        end
        req_prev = rom_req;
    end

    task automatic expect_val(input int kind, input int val, input int h, input int v);
        cexp_t e;
        e.cyc = cyc; e.kind = kind; e.val = val; e.h = h; e.v = v;
        expq.push_back(e);
    endtask

    function automatic int model_colour(input int v, input int h);
        if (h < 640 && v < 480) begin
            for (int i = 0; i < st_col.size(); i++)
                if (int'(st_col[i]) == h / 40) return int'(st_dat[i][(h % 40) / 5]);
        end
        return 1;
    endfunction

    task automatic run_line(input int v, input bit is_disp, input bit do_rst);
        for (int h = 0; h < 800; h++) begin
            @(posedge clk); #1;
            counter_H = 10'(h);
            counter_V = 10'(v);
            if (do_rst && h == 700) reset = 1'b0;
            if (do_rst && h == 701) reset = 1'b1;
            if (do_rst && (h == 702 || h == 725)) begin
                expect_val(K_REQ, 0, h, v);
                expect_val(K_BUSY, 0, h, v);
            end
            if (!is_disp && h == 0) expect_val(K_CLR, 0, h, v);
            if (is_disp) begin
                if (h == 0) begin
                    expect_val(K_REQ, 0, h, v);
                    expect_val(K_OVF, int'(exp_ovf), h, v);
                    expect_val(K_LATE, int'(exp_late), h, v);
                    expect_val(K_QEMPTY, 0, h, v);
                    if (exp_busy >= 0) expect_val(K_BCNT, exp_busy, h, v);
                end
                expect_val(K_COL, model_colour(v, h), h, v);
            end
        end
    endtask

    task automatic fill_rom();
        for (int i = 0; i < 4; i++) rom_tab[i] = 8'($urandom);
    endtask

    // Reference: hits are visible slots on row N/40; the first four are fetched
    // in slot order when the ROM answers, only the first is issued otherwise.
    task automatic run_test(input logic [125:0] ents, input int pv, input int dv,
                            input int mode, input int dly, input bit do_rst);
        int n, nh;
        logic [3:0] row;
        logic [2:0] sub;
        logic [13:0] s;
        rexp_t r;
        test_id++;
        rom_mode = mode; rom_delay = dly;
        n = pv + 1; row = 4'(n / 40); sub = 3'((n % 40) / 5);
        st_col.delete(); st_dat.delete();
        nh = 0; exp_ovf = 0; exp_late = 0;
        for (int k = 0; k < 9; k++) begin
            s = ents[14*k +: 14];
            if (n < 480 && s[13:10] != 4'hF && s[7:4] == row) begin
                r.id = s[13:10]; r.orient = s[9:8]; r.line = sub;
                if (mode == 0 && nh < 4) begin
                    reqq.push_back(r);
                    st_col.push_back(s[3:0]);
                    st_dat.push_back(rom_tab[nh]);
                end else if (mode != 0 && nh == 0) begin
                    reqq.push_back(r);
                end
                nh++;
            end
        end
        if (mode == 0 && nh > 4) exp_ovf = 1;
        if (mode == 1 && nh > 0) exp_late = 1;
        exp_busy = (n >= 480) ? 0 : (nh == 0) ? 10 : -1;
        entities = ents;
        run_line(pv, 0, do_rst);
        entities = ALLF;
        run_line(dv, 1, 0);
    endtask

    initial begin : stim
        logic [125:0] e;
        logic [3:0] id, trow, tr;
        int pv, r;
        reset = 1'b0; counter_H = 10'd0; counter_V = 10'd0; entities = ALLF;
        repeat (3) @(posedge clk);
        #1;
        expect_val(K_REQ, 0, 0, 0);
        expect_val(K_BUSY, 0, 0, 0);
        expect_val(K_OVF, 0, 0, 0);
        expect_val(K_LATE, 0, 0, 0);
        expect_val(K_COL, 1, 0, 0);
        expect_val(K_FIELDS, 0, 0, 0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Single sprite, bit 0 lit: x=80 white, x=85 black on line 40.
        e = ALLF; e[13:0] = {4'd3, 2'd0, 8'h12};
        fill_rom(); rom_tab[0] = 8'b0000_0001;
        run_test(e, 39, 40, 0, 1, 0);

        // Five hits on row 1: four fetched, overflow raised.
        e = ALLF;
        for (int k = 0; k < 5; k++) e[14*k +: 14] = {4'(k), 2'(k), 4'd1, 4'(k + 3)};
        fill_rom();
        run_test(e, 39, 40, 0, 1, 0);

        // No visible sprites: scan only, ten busy cycles.
        fill_rom();
        run_test(ALLF, 39, 40, 0, 1, 0);

        // ROM never answers: late, request dropped at swap, nothing stored.
        e = ALLF; e[13:0] = {4'd9, 2'd2, 8'h17};
        fill_rom();
        run_test(e, 39, 40, 1, 1, 0);

        // Slots 2 and 5 share a tile: slot 2 data shown.
        e = ALLF;
        e[28 +: 14] = {4'd6, 2'd1, 8'h15};
        e[70 +: 14] = {4'd7, 2'd3, 8'h15};
        fill_rom(); rom_tab[0] = 8'h0F; rom_tab[1] = 8'hF0;
        run_test(e, 39, 40, 0, 2, 0);

        // Reset while waiting, then a stray rom_valid.
        e = ALLF; e[13:0] = {4'd2, 2'd0, 8'h10};
        fill_rom();
        run_test(e, 39, 40, 2, 1, 1);

        // Next line invisible (N=480): no prefetch even for row-12 tiles.
        e = ALLF; e[13:0] = {4'd1, 2'd0, 8'hC3}; e[14 +: 14] = {4'd5, 2'd1, 8'hB3};
        fill_rom();
        run_test(e, 479, 200, 0, 1, 0);

        // Last visible line (N=479, row 11, sprite row 7).
        e = ALLF; e[13:0] = {4'd8, 2'd1, 8'hB0}; e[14 +: 14] = {4'd4, 2'd2, 8'hBF};
        fill_rom();
        run_test(e, 478, 479, 0, 3, 0);

        for (int t = 0; t < 12; t++) begin
            pv = $urandom_range(0, 478);
            trow = 4'((pv + 1) / 40);
            e = ALLF;
            for (int k = 0; k < 9; k++) begin
                r = $urandom_range(0, 9);
                id = (r < 3) ? 4'hF : 4'($urandom_range(0, 14));
                tr = (r < 8) ? trow : 4'($urandom_range(0, 15));
                e[14*k +: 14] = {id, 2'($urandom_range(0, 3)), tr,
                                 4'($urandom_range(0, (t % 2 == 0) ? 3 : 15))};
            end
            fill_rom();
            run_test(e, pv, pv + 1, 0, $urandom_range(1, 4), 0);
        end

        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
